// File: rtl/call_dispatcher.sv
// Elevator call dispatcher: validates (origin, destination) requests, queues them in a
// small FIFO and issues one trip at a time on the en/in_origin/destination interface.
module call_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NFLOORS = 5,
  parameter int unsigned FW      = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [FW-1:0]                req_origin,
  input  logic [FW-1:0]                req_dest,
  output logic                         req_ready,
  output logic                         req_err,
  input  logic                         emergency_stop,
  input  logic                         idle,
  output logic                         en,
  output logic [FW-1:0]                in_origin,
  output logic [FW-1:0]                destination,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [FW-1:0] r_mem_o [DEPTH];
  logic [FW-1:0] r_mem_d [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [FW-1:0] r_org, r_dst;
  logic          r_en, r_busy, r_err;
  logic          w_invalid, w_hs, w_push, w_pop;
  logic          w_en_nxt, w_busy_nxt;

  assign w_invalid = (32'(req_origin) >= NFLOORS) | (32'(req_dest) >= NFLOORS)
                   | (req_origin == req_dest);
  assign req_ready = 32'(r_count) < DEPTH;
  assign w_hs      = req_valid & req_ready;
  assign w_push    = w_hs & ~w_invalid;
  // Pop reads only registered occupancy, so a same-cycle push is never bypassed.
  assign w_pop     = (r_state == S_IDLE) & (r_count != '0) & idle & ~emergency_stop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_o[r_wr_ptr] <= req_origin;
      r_mem_d[r_wr_ptr] <= req_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_org    <= '0;
      r_dst    <= '0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_hs & w_invalid;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_org    <= r_mem_o[r_rd_ptr];
        r_dst    <= r_mem_d[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_ACK;
      S_ACK:   if (!idle) w_state_nxt = S_RUN;
      S_RUN:   if (idle)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_en_nxt   = 1'b0;
    w_busy_nxt = r_busy;
    case (r_state)
      S_IDLE: begin
        w_en_nxt   = w_pop;
        w_busy_nxt = w_pop;
      end
      S_ACK: begin
        w_en_nxt   = idle;
        w_busy_nxt = 1'b1;
      end
      S_RUN: begin
        w_en_nxt   = 1'b0;
        w_busy_nxt = ~idle;
      end
      default: begin
        w_en_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign en          = r_en;
  assign busy        = r_busy;
  assign in_origin   = r_org;
  assign destination = r_dst;
  assign count       = r_count;
  assign req_err     = r_err;

endmodule

// File: tb/tb_call_dispatcher.sv
// Bench for call_dispatcher: queue-based reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_call_dispatcher;

  localparam int DEPTH   = 4;
  localparam int NFLOORS = 5;
  localparam int FW      = 3;
  localparam int TRIP    = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_origin = '0;
  logic [FW-1:0] req_dest = '0;
  logic          req_ready, req_err;
  logic          emergency_stop = 1'b0;
  logic          idle = 1'b1;
  logic          en, busy;
  logic [FW-1:0] in_origin, destination;
  logic [2:0]    count;

  call_dispatcher #(.DEPTH(DEPTH), .NFLOORS(NFLOORS), .FW(FW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_origin(req_origin),
    .req_dest(req_dest), .req_ready(req_ready), .req_err(req_err),
    .emergency_stop(emergency_stop), .idle(idle), .en(en), .in_origin(in_origin),
    .destination(destination), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending calls in a queue, trip progress in two flags.
  int   m_qo[$];
  int   m_qd[$];
  int   m_org, m_dst;
  bit   m_en, m_busy, m_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_qo.delete(); m_qd.delete();
      m_org = 0; m_dst = 0; m_en = 0; m_busy = 0; m_err = 0;
    end else begin
      bit hs, inv, start;
      hs    = req_valid && (m_qo.size() < DEPTH);
      inv   = (req_origin >= NFLOORS) || (req_dest >= NFLOORS) || (req_origin == req_dest);
      start = !m_busy && (m_qo.size() > 0) && idle && !emergency_stop;
      m_err = hs && inv;
      if (start) begin
        m_org = m_qo.pop_front();
        m_dst = m_qd.pop_front();
        m_en = 1; m_busy = 1;
      end else if (m_en && !idle) begin
        m_en = 0;
      end else if (m_busy && !m_en && idle) begin
        m_busy = 0;
      end
      if (hs && !inv) begin
        m_qo.push_back(int'(req_origin));
        m_qd.push_back(int'(req_dest));
      end
    end
  end

  bit chk_on = 0;
  bit prev_en = 0;
  int err_pulses = 0;
  int log_o[$];
  int log_d[$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en", int'(en), int'(m_en));
      chk("busy", int'(busy), int'(m_busy));
      chk("in_origin", int'(in_origin), m_org);
      chk("destination", int'(destination), m_dst);
      chk("count", int'(count), m_qo.size());
      chk("req_ready", int'(req_ready), int'(m_qo.size() < DEPTH));
      chk("req_err", int'(req_err), int'(m_err));
    end
    if (req_err) err_pulses++;
    if (en && !prev_en) begin
      log_o.push_back(int'(in_origin));
      log_d.push_back(int'(destination));
    end
    prev_en = en;
  end

  // Elevator stand-in: acknowledges en by dropping idle, then travels TRIP cycles.
  bit elev_on = 0;
  int elev_cnt = 0;
  always @(negedge clk) begin
    if (elev_on) begin
      if (idle && en) begin
        idle = 1'b0;
        elev_cnt = TRIP;
      end else if (!idle) begin
        if (elev_cnt > 0) elev_cnt--;
        else idle = 1'b1;
      end
    end
  end

  task automatic push(input int o, input int d);
    req_valid  = 1'b1;
    req_origin = FW'(o);
    req_dest   = FW'(d);
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_not_busy(input int limit, input string name);
    int i;
    i = 0;
    while ((busy || count != 0) && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_timeout"}, int'(i < limit), 1);
  endtask

  initial begin
    int exp_o[5];
    int exp_d[5];
    int e0, i;
    exp_o = '{0, 3, 4, 2, 1};
    exp_d = '{2, 1, 0, 3, 3};

    // Reset state
    #2;
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_in_origin", int'(in_origin), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_on = 1;

    // Single trip (1,4)
    elev_on = 1;
    @(negedge clk);
    push(1, 4);
    chk("t2_count_after_push", int'(count), 1);
    chk("t2_en_before_pop", int'(en), 0);
    @(negedge clk);
    chk("t2_en", int'(en), 1);
    chk("t2_in_origin", int'(in_origin), 1);
    chk("t2_destination", int'(destination), 4);
    chk("t2_count_after_pop", int'(count), 0);
    @(negedge clk);
    chk("t2_en_dropped", int'(en), 0);
    chk("t2_busy_run", int'(busy), 1);
    chk("t2_dest_held", int'(destination), 4);
    wait_not_busy(60, "t2");
    chk("t2_busy_end", int'(busy), 0);

    // Queue order, full, rd_ptr wrap
    elev_on = 0;
    idle = 1'b0;
    @(negedge clk);
    push(0, 2); push(3, 1); push(4, 0); push(2, 3);
    chk("t3_count_full", int'(count), 4);
    chk("t3_ready_full", int'(req_ready), 0);
    req_valid = 1'b1; req_origin = 3'd1; req_dest = 3'd3;
    repeat (3) @(negedge clk);
    chk("t3_count_held", int'(count), 4);
    idle = 1'b1;
    elev_on = 1;
    i = 0;
    while (!req_ready && i < 50) begin @(negedge clk); i++; end
    chk("t3_ready_timeout", int'(i < 50), 1);
    @(negedge clk);
    req_valid = 1'b0;
    i = 0;
    while (!(log_o.size() >= 6 && !busy && count == 0) && i < 400) begin @(negedge clk); i++; end
    chk("t3_trips_timeout", int'(i < 400), 1);
    chk("t3_trip_count", log_o.size(), 6);
    for (int k = 0; k < 5; k++) begin
      if (k + 1 < log_o.size()) begin
        chk("t3_order_origin", log_o[k+1], exp_o[k]);
        chk("t3_order_dest", log_d[k+1], exp_d[k]);
      end
    end

    // Invalid requests
    elev_on = 0;
    e0 = err_pulses;
    push(5, 1); @(negedge clk);
    push(2, 2); @(negedge clk);
    push(1, 7); @(negedge clk);
    chk("t4_err_pulses", err_pulses - e0, 3);
    chk("t4_count", int'(count), 0);

    // Emergency stop inhibits dispatch
    idle = 1'b1;
    emergency_stop = 1'b1;
    push(0, 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_en_inhibited", int'(en), 0);
    end
    emergency_stop = 1'b0;
    @(negedge clk);
    chk("t5_en_released", int'(en), 1);
    chk("t5_in_origin", int'(in_origin), 0);
    chk("t5_destination", int'(destination), 3);
    elev_on = 1;
    wait_not_busy(60, "t5");

    // Push and pop in the same cycle, then reset mid-trip
    elev_on = 0;
    idle = 1'b0;
    push(2, 4);
    chk("t6_count_one", int'(count), 1);
    idle = 1'b1;
    push(3, 0);
    chk("t6_count_pushpop", int'(count), 1);
    chk("t6_en", int'(en), 1);
    chk("t6_in_origin", int'(in_origin), 2);
    elev_on = 1;
    i = 0;
    while (!(busy && !en) && i < 20) begin @(negedge clk); i++; end
    chk("t6_run_timeout", int'(i < 20), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_en", int'(en), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_in_origin", int'(in_origin), 0);
    chk("t6_rst_destination", int'(destination), 0);
    elev_on = 0;
    idle = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_post_en", int'(en), 0);
    chk("t6_post_count", int'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
